// File: rtl/gray_decoder_pkg.sv
// -----------------------------------------------------------------------------
// gray_decoder_pkg
// Shared definitions for the gray-code receive path: the default sample
// width and the decoder FSM state encoding.
// -----------------------------------------------------------------------------
package gray_decoder_pkg;

  // Default bit width of the gray input / binary output.
  localparam int GD_WIDTH = 3;

  // Decoder FSM states. The encoding is fixed so that the states can be
  // recognised on a debug bus.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,  // waiting for the first sample (no reference yet)
    ST_TRACK = 2'b01,  // reference held, every sample is step-checked
    ST_ERR   = 2'b10   // illegal step seen, converting only until Clear
  } gd_state_e;

endpackage : gray_decoder_pkg

// File: rtl/gray_decoder_if.sv
// -----------------------------------------------------------------------------
// gray_decoder_if
// Bundles the sample input and the status outputs of gray_decoder.
//   clear     : synchronous soft clear
//   valid     : gray carries a sample this cycle
//   gray      : gray-coded sample
//   bin       : registered binary value of the last accepted sample
//   bin_valid : pulse, bin updated this cycle
//   hold      : pulse, sample equal to the previous one
//   step_err  : pulse, illegal step detected
//   error     : level, decoder in ERR
//   wrapped   : sticky, a legal max->0 step has occurred
//   locked    : level, decoder in TRACK
// Modports: master = sample source, slave = decoder.
// -----------------------------------------------------------------------------
interface gray_decoder_if #(
  parameter int WIDTH = gray_decoder_pkg::GD_WIDTH
);

  logic             clear;
  logic             valid;
  logic [WIDTH-1:0] gray;
  logic [WIDTH-1:0] bin;
  logic             bin_valid;
  logic             hold;
  logic             step_err;
  logic             error;
  logic             wrapped;
  logic             locked;

  modport master (
    output clear, valid, gray,
    input  bin, bin_valid, hold, step_err, error, wrapped, locked
  );

  modport slave (
    input  clear, valid, gray,
    output bin, bin_valid, hold, step_err, error, wrapped, locked
  );

endinterface : gray_decoder_if

// File: rtl/gray_decoder_gray2bin.sv
// -----------------------------------------------------------------------------
// gray2bin
// Combinational gray-to-binary converter.
//   g_i : gray-coded input  (WIDTH bits)
//   b_o : binary output     (WIDTH bits)
// Each binary bit is the XOR of the gray bits at and above its position.
// Writing it as a reduction per bit avoids a self-referencing ripple chain.
// -----------------------------------------------------------------------------
module gray2bin #(
  parameter int WIDTH = gray_decoder_pkg::GD_WIDTH
) (
  input  logic [WIDTH-1:0] g_i,
  output logic [WIDTH-1:0] b_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign b_o[i] = ^g_i[WIDTH-1:i];
  end

endmodule : gray2bin

// File: rtl/gray_decoder.sv
// -----------------------------------------------------------------------------
// gray_decoder
// Receives a stream of gray codes, converts each to binary and checks that
// consecutive samples advance by exactly +1 (mod 2^WIDTH). Reports repeated
// codes, illegal steps and wrap-around.
// Ports:
//   clk_i  : clock, all state updates on the rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : gray_decoder_if.slave (sample input and status outputs)
// -----------------------------------------------------------------------------
module gray_decoder
  import gray_decoder_pkg::*;
#(
  parameter int WIDTH = GD_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  gray_decoder_if.slave        bus
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  gd_state_e        state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic             bin_valid_q, bin_valid_d;
  logic             hold_q, hold_d;
  logic             step_err_q, step_err_d;
  logic             wrapped_q, wrapped_d;

  logic [WIDTH-1:0] sample_bin;
  logic [WIDTH-1:0] delta;

  gray2bin #(.WIDTH(WIDTH)) u_gray2bin (
    .g_i (bus.gray),
    .b_o (sample_bin)
  );

  // Modular difference; the natural WIDTH-bit wrap gives mod 2^WIDTH.
  assign delta = sample_bin - prev_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned; otherwise synthesis infers a latch.
    state_d     = state_q;
    prev_d      = prev_q;
    bin_d       = bin_q;
    bin_valid_d = 1'b0;
    hold_d      = 1'b0;
    step_err_d  = 1'b0;
    wrapped_d   = wrapped_q;

    if (bus.clear) begin
      // A sample arriving with clear is dropped; bin keeps its value.
      state_d   = ST_IDLE;
      prev_d    = '0;
      wrapped_d = 1'b0;
    end else if (bus.valid) begin
      unique case (state_q)
        ST_IDLE: begin
          // First sample only establishes the reference.
          prev_d      = sample_bin;
          bin_d       = sample_bin;
          bin_valid_d = 1'b1;
          state_d     = ST_TRACK;
        end
        ST_TRACK: begin
          bin_valid_d = 1'b1;
          if (delta == ONE) begin
            // delta==1 landing on 0 means the previous value was the max.
            if (sample_bin == '0) wrapped_d = 1'b1;
            prev_d = sample_bin;
            bin_d  = sample_bin;
          end else if (delta == '0) begin
            hold_d = 1'b1;
          end else begin
            // Reference is frozen; ERR does no further checking.
            step_err_d = 1'b1;
            bin_d      = sample_bin;
            state_d    = ST_ERR;
          end
        end
        ST_ERR: begin
          bin_d       = sample_bin;
          bin_valid_d = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values sampled at the same edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      prev_q      <= '0;
      bin_q       <= '0;
      bin_valid_q <= 1'b0;
      hold_q      <= 1'b0;
      step_err_q  <= 1'b0;
      wrapped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      bin_q       <= bin_d;
      bin_valid_q <= bin_valid_d;
      hold_q      <= hold_d;
      step_err_q  <= step_err_d;
      wrapped_q   <= wrapped_d;
    end
  end

  assign bus.bin       = bin_q;
  assign bus.bin_valid = bin_valid_q;
  assign bus.hold      = hold_q;
  assign bus.step_err  = step_err_q;
  assign bus.wrapped   = wrapped_q;
  assign bus.locked    = (state_q == ST_TRACK);
  assign bus.error     = (state_q == ST_ERR);

endmodule : gray_decoder

// File: doc/gray_decoder.md
Name: gray_decoder

Overview:
Receive-side partner of the gray-code counter. Accepts a stream of WIDTH-bit gray codes with a valid strobe, converts each to binary, and checks that consecutive samples advance by exactly +1 (mod 2^WIDTH). Reports step errors, repeated codes, and sequence wrap-around. Sits downstream of the counter, or of any gray-coded position source, in the lab datapath.

Parameters:
WIDTH, 3, bit width of gray input and binary output (>=2)

Ports:
Clk  input  1  system clock, all state updates on posedge
Reset  input  1  asynchronous, active-low reset; low forces the reset state immediately
Clear  input  1  synchronous soft clear: return to IDLE, drop sticky flags
Valid  input  1  GrayIn carries a sample this cycle
GrayIn  input  WIDTH  gray-coded sample
BinOut  output  WIDTH  registered binary value of the last accepted sample
BinValid  output  1  one-cycle pulse; BinOut updated this cycle
Hold  output  1  one-cycle pulse; accepted sample equal to previous (delta 0)
StepErr  output  1  one-cycle pulse; illegal step detected
Error  output  1  level; FSM in ERR
Wrapped  output  1  sticky; a legal max->0 step has occurred
Locked  output  1  level; FSM in TRACK

Behaviour:
- Reset low (async): state=IDLE; BinOut=0, BinValid=0, Hold=0, StepErr=0, Error=0, Wrapped=0, Locked=0; internal prev=0.
- Conversion: b[WIDTH-1]=g[WIDTH-1]; b[i]=b[i+1]^g[i], i descending. Purely combinational, then registered.
- Latency: sample at edge N -> BinOut/BinValid/Hold/StepErr valid after edge N, i.e. 1 cycle.
- Pulses (BinValid, Hold, StepErr) are deasserted every cycle without a qualifying event.
- BinOut holds its value when no sample is accepted.
- FSM:
  - IDLE
    - Valid: capture prev=bin, BinOut=bin, BinValid=1, go TRACK. No step check on the first sample.
  - TRACK, on Valid, with delta=(bin-prev) mod 2^WIDTH:
    - delta=1: accept, prev=bin, BinOut=bin, BinValid=1. If prev was 2^WIDTH-1 and bin=0, set Wrapped (sticky).
    - delta=0: Hold=1, BinValid=1, BinOut unchanged, stay.
    - other: StepErr=1, BinOut=bin, BinValid=1, go ERR. prev is not updated.
  - ERR
    - Valid samples are still converted (BinOut/BinValid update).
    - No checking and no StepErr pulses.
    - Error=1 until Clear.
- Clear (any state): next state IDLE, Wrapped=0, Error=0, prev=0.
  - Same-cycle Valid is discarded: no BinValid. BinOut keeps its value.
- Locked=1 iff state==TRACK. Error=1 iff state==ERR.
- Wrapped is not cleared by further wraps or errors; only Clear or Reset clears it.
- Reset asserted mid-stream: immediate return to reset values. The first sample after release is treated as an IDLE capture.

Decomposition:
- Shared package: state encoding constants (IDLE=2'b00, TRACK=2'b01, ERR=2'b10) and the WIDTH default.
- One natural sub-module: gray2bin, parameterised WIDTH, combinational conversion. Reusable by other blocks.
- FSM, delta compare and flags stay in gray_decoder.

Test Plan:
- Reset low then high; Valid with 000,001,011,010,110,111,101,100 on consecutive cycles -> BinOut 0..7, one cycle later each; BinValid high 8 cycles; StepErr=0; Locked=1 from the 2nd edge.
- Continue with 000 -> BinOut=0, Wrapped=1 and stays 1 through a further 001,011.
- From TRACK at 001, send 010 (bin 3) -> StepErr one-cycle pulse, BinOut=3, Error=1, Locked=0; a following sample 110 gives BinOut=4 and no StepErr.
- In TRACK at 011, send 011 again -> Hold pulse, BinValid=1, BinOut=2, no error; then 010 -> normal accept, BinOut=3.
- Clear and Valid (GrayIn=111) in the same cycle while in ERR -> no BinValid, BinOut unchanged, Error=0, Wrapped=0, state IDLE; next 111 is captured with no check (BinOut=5).
- Assert Reset mid-stream between clock edges -> all outputs zero before the next edge; after release, first sample 101 gives BinOut=6, Locked=1, no StepErr.
